// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of N_CDB registered broadcast slots among N_REQ writeback requesters.
// Define CDB_ARB_BRANCH_PRIO_EN to give requester 0 fixed priority on slot 0.
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int N_CDB = 2,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W = 32,
  localparam int ROB_W = $clog2(ROB_DEPTH),
  localparam int SW = $clog2(N_REQ),
  localparam int CW = N_CDB > 1 ? $clog2(N_CDB) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][ROB_W-1:0]      req_rob_id,
  input  logic [N_REQ-1:0][DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_CDB-1:0]                 cdb_valid,
  output logic [N_CDB-1:0][ROB_W-1:0]      cdb_rob_id,
  output logic [N_CDB-1:0][DATA_W-1:0]     cdb_data,
  output logic [N_CDB-1:0][SW-1:0]         cdb_src,
  output logic [31:0]                      conflict_cnt
);
`ifdef CDB_ARB_BRANCH_PRIO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int RING = N_REQ - FIRST;
  logic [SW-1:0] rr_q, rr_d;
  logic [31:0] conflict_q, conflict_d;
  logic [N_CDB-1:0] slot_vld, cdb_valid_q;
  logic [N_CDB-1:0][SW-1:0] slot_src, cdb_src_q;
  logic [N_CDB-1:0][ROB_W-1:0] cdb_rob_q;
  logic [N_CDB-1:0][DATA_W-1:0] cdb_data_q;
  // The round-robin ring covers FIRST..N_REQ-1; requester 0 sits outside it in priority mode.
  always_comb begin
    int n, idx, last;
    n = 0;
    idx = 0;
    last = -1;
    req_ready = '0;
    slot_vld = '0;
    slot_src = '0;
    if (FIRST == 1 && req_valid[0]) begin
      req_ready[0] = 1'b1;
      slot_vld[0] = 1'b1;
      n = 1;
    end
    for (int j = 0; j < RING; j++) begin
      idx = FIRST + (int'(rr_q) - FIRST + j) % RING;
      if (req_valid[SW'(idx)] && n < N_CDB) begin
        req_ready[SW'(idx)] = 1'b1;
        slot_vld[CW'(n)] = 1'b1;
        slot_src[CW'(n)] = SW'(idx);
        n++;
        last = idx;
      end
    end
    if (rst || flush) begin
      req_ready = '0;
      slot_vld = '0;
      slot_src = '0;
    end
    rr_d = (rst || flush) ? SW'(FIRST) : last < 0 ? rr_q : SW'(FIRST + (last + 1 - FIRST) % RING);
    conflict_d = (!flush && |(req_valid & ~req_ready) && conflict_q != '1) ? conflict_q + 32'd1 : conflict_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= SW'(FIRST);
      conflict_q <= '0;
      cdb_valid_q <= '0;
      cdb_src_q <= '0;
      cdb_rob_q <= '0;
      cdb_data_q <= '0;
    end else begin
      rr_q <= rr_d;
      conflict_q <= conflict_d;
      cdb_valid_q <= slot_vld;
      cdb_src_q <= slot_src;
      for (int k = 0; k < N_CDB; k++) begin
        cdb_rob_q[k] <= slot_vld[k] ? req_rob_id[slot_src[k]] : '0;
        cdb_data_q[k] <= slot_vld[k] ? req_data[slot_src[k]] : '0;
      end
    end
  end
  assign cdb_valid = cdb_valid_q;
  assign cdb_src = cdb_src_q;
  assign cdb_rob_id = cdb_rob_q;
  assign cdb_data = cdb_data_q;
  assign conflict_cnt = conflict_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, hand-written corner sequences and randomized traffic
// checked against a list-based round-robin reference model.
module tb_cdb_arbiter;
  localparam int N_REQ = 4;
  localparam int N_CDB = 2;
  localparam int ROB_W = 3;
  localparam int DATA_W = 32;
  localparam int SW = 2;
`ifdef CDB_ARB_BRANCH_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush;
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [N_REQ-1:0][ROB_W-1:0] req_rob_id;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_CDB-1:0] cdb_valid;
  logic [N_CDB-1:0][ROB_W-1:0] cdb_rob_id;
  logic [N_CDB-1:0][DATA_W-1:0] cdb_data;
  logic [N_CDB-1:0][SW-1:0] cdb_src;
  logic [31:0] conflict_cnt;
  cdb_arbiter #(.N_REQ(N_REQ), .N_CDB(N_CDB), .ROB_DEPTH(8), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: eligible requesters as a list rotated to start at the pointer.
  int mptr = PRIO ? 1 : 0;
  int nptr;
  logic [31:0] mcnt = '0;
  logic [31:0] ncnt;
  int g[$];
  logic [N_REQ-1:0] m_ready;
  logic [N_CDB-1:0] m_v;
  logic [N_CDB-1:0][ROB_W-1:0] m_rob;
  logic [N_CDB-1:0][DATA_W-1:0] m_data;
  logic [N_CDB-1:0][SW-1:0] m_src;
  task automatic model_eval();
    int ring[$];
    int last;
    g = {};
    last = -1;
    m_ready = '0;
    for (int i = int'(PRIO); i < N_REQ; i++) ring.push_back(i);
    for (int r = 0; r < N_REQ && ring[0] != mptr; r++) ring.push_back(ring.pop_front());
    if (PRIO && req_valid[0]) g.push_back(0);
    foreach (ring[j])
      if (req_valid[ring[j]] && g.size() < N_CDB) begin
        g.push_back(ring[j]);
        last = j;
      end
    if (rst || flush) g = {};
    foreach (g[j]) m_ready[g[j]] = 1'b1;
    if (rst || flush) nptr = PRIO ? 1 : 0;
    else if (last >= 0) nptr = ring[(last + 1) % ring.size()];
    else nptr = mptr;
    if (rst) ncnt = '0;
    else if (!flush && (req_valid & ~m_ready) != '0 && mcnt != 32'hFFFF_FFFF) ncnt = mcnt + 1;
    else ncnt = mcnt;
  endtask
  task automatic model_commit();
    m_v = '0;
    m_rob = '0;
    m_data = '0;
    m_src = '0;
    foreach (g[k]) begin
      m_v[k] = 1'b1;
      m_src[k] = SW'(g[k]);
      m_rob[k] = req_rob_id[g[k]];
      m_data[k] = req_data[g[k]];
    end
    mptr = nptr;
    mcnt = ncnt;
  endtask
  task automatic pre(input string tag);
    #1;
    model_eval();
    chk({tag, " ready"}, 64'(req_ready), 64'(m_ready));
  endtask
  task automatic post(input string tag);
    @(posedge clk);
    model_commit();
    #1;
    chk({tag, " cdb_valid"}, 64'(cdb_valid), 64'(m_v));
    chk({tag, " cdb_src"}, 64'(cdb_src), 64'(m_src));
    chk({tag, " cdb_rob_id"}, 64'(cdb_rob_id), 64'(m_rob));
    chk({tag, " cdb_data"}, 64'(cdb_data), 64'(m_data));
    chk({tag, " conflict_cnt"}, 64'(conflict_cnt), 64'(mcnt));
  endtask
  typedef struct {
    logic [3:0] vld;
    logic fl;
    logic [3:0] rdy;
    logic [1:0] cv;
    logic [1:0] s0, s1;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[11];
  logic [N_REQ-1:0][ROB_W-1:0] base_rob;
  logic [N_REQ-1:0][DATA_W-1:0] base_data;
  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 2'b01, 2'd0, 2'd0, 32'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 2'b00, 2'd0, 2'd0, 32'd0};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 32'd1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3, 32'd2};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 32'd3};
    tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'b01, 2'd2, 2'd0, 32'd3};
    tbl[6]  = '{4'b1001, 1'b0, 4'b1001, 2'b11, 2'd3, 2'd0, 32'd3};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 2'b00, 2'd0, 2'd0, 32'd3};
    tbl[8]  = '{4'b0110, 1'b0, 4'b0110, 2'b11, 2'd1, 2'd2, 32'd3};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 32'd3};
    tbl[10] = '{4'b0111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 32'd4};
    for (int i = 0; i < N_REQ; i++) begin
      base_rob[i] = ROB_W'(5 + i);
      base_data[i] = 32'hDEAD + 32'(i);
    end
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_rob_id = base_rob;
    req_data = base_data;
    @(negedge clk);
    pre("reset");
    post("reset");
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset conflict_cnt", 64'(conflict_cnt), 64'd0);
`ifndef CDB_ARB_BRANCH_PRIO_EN
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = 1'b0;
      req_valid = tbl[i].vld;
      flush = tbl[i].fl;
      pre($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl ready", i), 64'(req_ready), 64'(tbl[i].rdy));
      post($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl cdb_valid", i), 64'(cdb_valid), 64'(tbl[i].cv));
      chk($sformatf("vec%0d tbl src0", i), 64'(cdb_src[0]), 64'(tbl[i].s0));
      chk($sformatf("vec%0d tbl src1", i), 64'(cdb_src[1]), 64'(tbl[i].s1));
      chk($sformatf("vec%0d tbl rob0", i), 64'(cdb_rob_id[0]), tbl[i].cv[0] ? 64'(base_rob[tbl[i].s0]) : 64'd0);
      chk($sformatf("vec%0d tbl data0", i), 64'(cdb_data[0]), tbl[i].cv[0] ? 64'(base_data[tbl[i].s0]) : 64'd0);
      chk($sformatf("vec%0d tbl data1", i), 64'(cdb_data[1]), tbl[i].cv[1] ? 64'(base_data[tbl[i].s1]) : 64'd0);
      chk($sformatf("vec%0d tbl conflict", i), 64'(conflict_cnt), 64'(tbl[i].cnt));
    end
`else
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0010;
    pre("prio setup");
    post("prio setup");
    @(negedge clk);
    req_valid = 4'b1111;
    pre("prio a");
    post("prio a");
    chk("prio a src0", 64'(cdb_src[0]), 64'd0);
    chk("prio a src1", 64'(cdb_src[1]), 64'd2);
    pre("prio b");
    post("prio b");
    chk("prio b src0", 64'(cdb_src[0]), 64'd0);
    chk("prio b src1", 64'(cdb_src[1]), 64'd3);
`endif
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 4'b1111;
    pre("contend");
    post("contend");
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    pre("rst+flush");
    chk("rst+flush ready", 64'(req_ready), 64'd0);
    post("rst+flush");
    chk("rst+flush cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst+flush cdb_data", 64'(cdb_data), 64'd0);
    chk("rst+flush conflict", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 4'b0100;
    pre("after rst");
    post("after rst");
    chk("after rst cdb_valid", 64'(cdb_valid), 64'b01);
    chk("after rst src0", 64'(cdb_src[0]), 64'd2);
    chk("after rst rob0", 64'(cdb_rob_id[0]), 64'(base_rob[2]));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] || m_ready[i]) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          req_rob_id[i] = ROB_W'($urandom);
          req_data[i] = $urandom;
        end else if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 63) == 0;
      pre("rnd");
      post("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares N_CDB common-data-bus broadcast slots among N_REQ functional-unit writeback requesters (ALU, MUL, later LSU/branch) using a round-robin scheme.
- Produces registered CDB slot outputs that feed ROB commit marking and reservation-station wakeup.
- On a mispredict flush, drops all in-flight broadcasts.

Parameters:
- N_REQ, 4, number of FU requesters; must be at least 2.
- N_CDB, 2, number of CDB broadcast slots per cycle; must be between 1 and N_REQ.
- ROB_DEPTH, 8, ROB entries; ROB_W = $clog2(ROB_DEPTH).
- DATA_W, 32, result value width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  ROB mispredict flush.
- req_valid  input  [N_REQ]  FU has a completed result.
- req_rob_id  input  [N_REQ][ROB_W]  ROB tag of the result.
- req_data  input  [N_REQ][DATA_W]  result value.
- req_ready  output  [N_REQ]  grant; combinational, same cycle.
- cdb_valid  output  [N_CDB]  slot carries a broadcast.
- cdb_rob_id  output  [N_CDB][ROB_W]  broadcast tag.
- cdb_data  output  [N_CDB][DATA_W]  broadcast value.
- cdb_src  output  [N_CDB][$clog2(N_REQ)]  index of the granted requester.
- conflict_cnt  output  32  saturating count of cycles with at least one valid requester left ungranted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cdb_valid=0, cdb_rob_id=0, cdb_data=0, cdb_src=0, conflict_cnt=0, rr_ptr=0.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - The requester holds valid and payload stable until granted.
  - req_ready[i] is 1 only when req_valid[i] is 1.
- Arbitration (combinational each cycle):
  - Scan indices rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Grant the first up-to-N_CDB valid requesters.
  - The k-th grant in scan order maps to slot k.
- Latency: exactly 1 cycle. Grant at cycle t gives cdb_valid[k]=1 at t+1 with the captured tag, data and source.
- Unused slots: cdb_valid[k]=0 and tag/data/src forced to 0. Idle cycles drive all slots invalid.
- Pointer update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - If no grants: rr_ptr holds.
- Wrap-around: with N_REQ=4 and rr_ptr=3, scan order is 3,0,1,2.
- Full contention (all N_REQ valid): exactly N_CDB grants per cycle. A pending requester waits at most ceil(N_REQ/N_CDB)-1 cycles.
- flush=1 during cycle t:
  - All req_ready=0 in cycle t.
  - cdb_valid=0 at t+1.
  - rr_ptr <= 0.
  - conflict_cnt holds.
  - Any broadcast already registered at t is still visible during t; the ROB ignores it under flush.
- conflict_cnt:
  - Increments when (flush=0) and some req_valid[i]=1 with req_ready[i]=0.
  - Saturates at 0xFFFFFFFF.
- rst takes precedence over flush. Reset mid-contention discards all grants; the first grant after reset starts scanning from index 0.
- A requester whose valid drops before it is granted is simply skipped; no error is raised.

Optional Feature:
- Macro: CDB_ARB_BRANCH_PRIO_EN.
- Defined:
  - Requester 0 (branch-capable ALU) is granted slot 0 whenever req_valid[0]=1, regardless of rr_ptr.
  - The remaining N_CDB-1 slots are granted round-robin over requesters 1..N_REQ-1.
  - rr_ptr cycles over 1..N_REQ-1 only and resets to 1.
  - This gives earlier mispredict resolution.
- Undefined: pure round-robin over all requesters as described above.

Test Plan:
1. Reset, then req_valid=4'b0001, tag=5, data=0xDEAD -> req_ready=4'b0001 same cycle; next cycle cdb_valid=2'b01, cdb_rob_id[0]=5, cdb_data[0]=0xDEAD, cdb_src[0]=0; rr_ptr=1.
2. All 4 requesters valid and held for 3 cycles from rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; conflict_cnt=3.
3. rr_ptr=3, req_valid=4'b1001 -> slot0 src=3, slot1 src=0; rr_ptr becomes 1.
4. Grants issued in cycle t with flush=1 in cycle t -> req_ready=0 in t; cdb_valid=0 at t+1; rr_ptr=0; conflict_cnt unchanged.
5. rst asserted mid-contention while flush=1 -> all outputs 0 next cycle; the subsequent single request from requester 2 broadcasts on slot 0 with src=2.
6. With CDB_ARB_BRANCH_PRIO_EN, rr_ptr=2, all valid -> slot0 src=0, slot1 src=2 -> next cycle slot0 src=0, slot1 src=3.
